// File: rtl/axis_to_vector.sv
// Assembles BEATS = VEC_BYTES/AXIS_BYTES AXI-Stream beats into one wide vector (valid/ready out).
// Optional tlast framing check enabled by defining AXIS_TO_VECTOR_TLAST_CHECK_EN.
module axis_to_vector #(
  parameter int VEC_BYTES  = 1,
  parameter int AXIS_BYTES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_tready,
  input  logic                    axis_tvalid,
  input  logic                    axis_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_tdata,
  output logic [VEC_BYTES*8-1:0]  vec,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic                    err
);

  localparam int BEATS = VEC_BYTES / AXIS_BYTES;
  localparam int CTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = AXIS_BYTES * 8;
  localparam int VW    = VEC_BYTES * 8;
  localparam logic [CTR_W-1:0] LAST = CTR_W'(BEATS - 1);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [VW-1:0]    asm_q, asm_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic             asm_full_q, asm_full_d;
  logic             tready_q;

  logic             beat_acc;
  logic             vec_acc;
  logic             final_beat;
  logic             early_last;
  logic [CTR_W-1:0] slot;
  logic [VW-1:0]    merged;

  assign beat_acc   = axis_tvalid && tready_q;
  assign vec_acc    = vec_valid_q && vec_ready;
  assign final_beat = (ctr_q == LAST);
  assign slot       = (MSB_FIRST != 0) ? (LAST - ctr_q) : ctr_q;

`ifdef AXIS_TO_VECTOR_TLAST_CHECK_EN
  logic err_q, err_d;

  assign early_last = axis_tlast && !final_beat;

  // Both an early tlast and a missing tlast on the final beat are framing errors.
  always_comb begin
    err_d = beat_acc && (early_last || (final_beat && !axis_tlast));
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_tlast;

  assign unused_tlast = axis_tlast;
  assign early_last   = 1'b0;
  assign err          = 1'b0;
`endif

  always_comb begin
    merged = asm_q;
    for (int s = 0; s < BEATS; s++) begin
      if (CTR_W'(s) == slot) begin
        merged[s*SW +: SW] = axis_tdata;
      end
    end
  end

  always_comb begin
    ctr_d       = ctr_q;
    asm_d       = asm_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    asm_full_d  = asm_full_q;

    if (vec_acc) begin
      if (asm_full_q) begin
        vec_d      = asm_q;
        asm_full_d = 1'b0;
      end else begin
        vec_valid_d = 1'b0;
      end
    end

    // A beat can only be accepted while asm is free, so asm_full_q is 0 here.
    if (beat_acc) begin
      asm_d = merged;
      if (early_last) begin
        ctr_d = '0;
      end else if (!final_beat) begin
        ctr_d = ctr_q + 1'b1;
      end else begin
        ctr_d = '0;
        if (!vec_valid_q || vec_acc) begin
          vec_d       = merged;
          vec_valid_d = 1'b1;
        end else begin
          asm_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      ctr_q       <= '0;
      asm_q       <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      asm_full_q  <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      asm_q       <= asm_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      asm_full_q  <= asm_full_d;
      tready_q    <= !asm_full_d;
    end
  end

  assign axis_tready = tready_q;
  assign vec         = vec_q;
  assign vec_valid   = vec_valid_q;

endmodule
